// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: two-road intersection phase sequencer.
//   Steps ALL_RED_A -> NS_GREEN -> NS_YELLOW -> ALL_RED_B -> EW_GREEN ->
//   EW_YELLOW -> ALL_RED_A, one phase-second per sec_tick. A pedestrian
//   request shortens NS green and grants walk during the next EW green.
//   Optional flashing-yellow mode is compiled in with TRAFFIC_FLASH_EN.
// Ports:
//   clk, rst        clock, async active-high reset
//   sec_tick        one-clk pulse per second
//   ped_req         pedestrian button (level, sampled every clk)
//   flash_req       force flashing yellow (TRAFFIC_FLASH_EN only)
//   ns_light        north-south {red,yellow,green}
//   ew_light        east-west {red,yellow,green}
//   walk            pedestrian walk lamp
//   remain          ticks left in current phase minus one
//   phase_start     high for the first clk of each new phase
module traffic_phase_ctrl #(
  parameter int pNS_GREEN  = 30,
  parameter int pNS_YELLOW = 3,
  parameter int pEW_GREEN  = 25,
  parameter int pEW_YELLOW = 3,
  parameter int pALL_RED   = 1,
  parameter int pPED_CLAMP = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       ped_req,
`ifdef TRAFFIC_FLASH_EN
  input  logic       flash_req,
`endif
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [6:0] remain,
  output logic       phase_start
);

  typedef enum logic [2:0] {
    ALL_RED_A, NS_GREEN, NS_YELLOW, ALL_RED_B, EW_GREEN, EW_YELLOW
`ifdef TRAFFIC_FLASH_EN
    , FLASH
`endif
  } state_t;

  localparam logic [6:0] CLAMP = 7'(pPED_CLAMP);

  state_t     state, state_nxt;
  logic       adv;          // phase transition on this edge
  logic       ped_pending, pend_nxt, walk_nxt;
  logic [6:0] remain_nxt;
  logic [2:0] ns_nxt, ew_nxt;

  // Reload value for a phase: duration minus one.
  function automatic logic [6:0] dur_m1(input state_t s);
    case (s)
      NS_GREEN:  dur_m1 = 7'(pNS_GREEN - 1);
      NS_YELLOW: dur_m1 = 7'(pNS_YELLOW - 1);
      EW_GREEN:  dur_m1 = 7'(pEW_GREEN - 1);
      EW_YELLOW: dur_m1 = 7'(pEW_YELLOW - 1);
      ALL_RED_A,
      ALL_RED_B: dur_m1 = 7'(pALL_RED - 1);
      default:   dur_m1 = 7'd0;
    endcase
  endfunction

  // State register (all registered outputs live here too)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ALL_RED_A;
      remain      <= 7'(pALL_RED - 1);
      ns_light    <= 3'b100;
      ew_light    <= 3'b100;
      walk        <= 1'b0;
      ped_pending <= 1'b0;
      phase_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      remain      <= remain_nxt;
      ns_light    <= ns_nxt;
      ew_light    <= ew_nxt;
      walk        <= walk_nxt;
      ped_pending <= pend_nxt;
      phase_start <= adv;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    if (sec_tick && remain == 7'd0) begin
      adv = 1'b1;
      case (state)
        ALL_RED_A: state_nxt = NS_GREEN;
        NS_GREEN:  state_nxt = NS_YELLOW;
        NS_YELLOW: state_nxt = ALL_RED_B;
        ALL_RED_B: state_nxt = EW_GREEN;
        EW_GREEN:  state_nxt = EW_YELLOW;
        default:   state_nxt = ALL_RED_A;
      endcase
    end
`ifdef TRAFFIC_FLASH_EN
    // FLASH holds remain at 0, so override the generic zero-remain exit:
    // leave only on a tick with the request released.
    if (state == FLASH) begin
      adv       = sec_tick && !flash_req;
      state_nxt = adv ? ALL_RED_A : FLASH;
    end
    if (flash_req && state != FLASH) begin
      adv       = 1'b1;
      state_nxt = FLASH;
    end
`endif
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    ns_nxt = 3'b100;
    ew_nxt = 3'b100;
    case (state_nxt)
      NS_GREEN:  ns_nxt = 3'b001;
      NS_YELLOW: ns_nxt = 3'b010;
      EW_GREEN:  ew_nxt = 3'b001;
      EW_YELLOW: ew_nxt = 3'b010;
`ifdef TRAFFIC_FLASH_EN
      FLASH: begin
        if (state != FLASH) begin
          ns_nxt = 3'b010;
          ew_nxt = 3'b010;
        end else if (sec_tick) begin
          ns_nxt = ns_light ^ 3'b010;
          ew_nxt = ew_light ^ 3'b010;
        end else begin
          ns_nxt = ns_light;
          ew_nxt = ew_light;
        end
      end
`endif
      default: ;
    endcase

    // Not advancing implies remain != 0 on a tick, so no underflow.
    remain_nxt = remain;
    if (adv)
      remain_nxt = dur_m1(state_nxt);
    else if (sec_tick) begin
      if (state == NS_GREEN && ped_pending && remain > CLAMP)
        remain_nxt = CLAMP;
      else
        remain_nxt = remain - 7'd1;
    end
`ifdef TRAFFIC_FLASH_EN
    if (state_nxt == FLASH) remain_nxt = 7'd0;
`endif

    // Clamp above used the registered pending bit; a same-cycle press
    // only lands in pending for the following tick.
    walk_nxt = walk;
    pend_nxt = ped_pending | ped_req;
    if (adv && state_nxt == EW_GREEN) begin
      walk_nxt = ped_pending;
      pend_nxt = 1'b0;
    end else if (adv && state == EW_GREEN) begin
      walk_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed bench for traffic_phase_ctrl.
//   DUT a: short cycle (4/2/1/3/2) for sequencing, flash and reset checks.
//   DUT b: pNS_GREEN=30, clamp 5 for pedestrian behaviour.
//   Expected outputs are queued when a stimulus step is driven and popped
//   when the DUT result is sampled on the following negedge.
module tb_traffic_phase_ctrl;

  logic clk = 1'b0;
  logic rst_a, rst_b, tick_a, tick_b, ped_a, ped_b;
`ifdef TRAFFIC_FLASH_EN
  logic flash_a, flash_b;
`endif
  logic [2:0] ns_a, ew_a, ns_b, ew_b;
  logic       walk_a, walk_b, ps_a, ps_b;
  logic [6:0] rem_a, rem_b;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(.pNS_GREEN(4), .pNS_YELLOW(2), .pEW_GREEN(3),
                       .pEW_YELLOW(2), .pALL_RED(1), .pPED_CLAMP(5)) u_a (
    .clk(clk), .rst(rst_a), .sec_tick(tick_a), .ped_req(ped_a),
`ifdef TRAFFIC_FLASH_EN
    .flash_req(flash_a),
`endif
    .ns_light(ns_a), .ew_light(ew_a), .walk(walk_a), .remain(rem_a),
    .phase_start(ps_a));

  traffic_phase_ctrl #(.pNS_GREEN(30), .pNS_YELLOW(2), .pEW_GREEN(3),
                       .pEW_YELLOW(2), .pALL_RED(1), .pPED_CLAMP(5)) u_b (
    .clk(clk), .rst(rst_b), .sec_tick(tick_b), .ped_req(ped_b),
`ifdef TRAFFIC_FLASH_EN
    .flash_req(flash_b),
`endif
    .ns_light(ns_b), .ew_light(ew_b), .walk(walk_b), .remain(rem_b),
    .phase_start(ps_b));

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    logic [6:0] remain;
    logic       ps;
  } obs_t;

  localparam logic [5:0] L_AR  = 6'b100_100;
  localparam logic [5:0] L_NSG = 6'b001_100;
  localparam logic [5:0] L_NSY = 6'b010_100;
  localparam logic [5:0] L_EWG = 6'b100_001;
  localparam logic [5:0] L_EWY = 6'b100_010;

  obs_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic obs_t observe(input bit b);
    obs_t o;
    if (b) o = '{ns: ns_b, ew: ew_b, walk: walk_b, remain: rem_b, ps: ps_b};
    else   o = '{ns: ns_a, ew: ew_a, walk: walk_a, remain: rem_a, ps: ps_a};
    return o;
  endfunction

  task automatic push(input logic [5:0] lamps, input bit w, input int rem,
                      input bit ps);
    obs_t e;
    e = '{ns: lamps[5:3], ew: lamps[2:0], walk: w, remain: 7'(rem), ps: ps};
    exp_q.push_back(e);
  endtask

  task automatic check(input bit b, input string tag);
    obs_t e, o;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      o = observe(b);
      assert (o === e) else begin
        mismatched++;
        $error("FAIL %s: got ns=%b ew=%b walk=%b remain=%0d ps=%b, want ns=%b ew=%b walk=%b remain=%0d ps=%b",
               tag, o.ns, o.ew, o.walk, o.remain, o.ps, e.ns, e.ew, e.walk, e.remain, e.ps);
      end
    end
  endtask

  // One sec_tick (optionally with a coincident ped_req), then the edge
  // result and the following idle cycle are checked; ~10 clk per tick.
  task automatic tick(input bit b, input logic [5:0] lamps, input bit w,
                      input int rem, input bit ps, input bit ped, input string tag);
    push(lamps, w, rem, ps);
    push(lamps, w, rem, 1'b0);
    if (b) begin tick_b = 1'b1; ped_b = ped; end
    else   begin tick_a = 1'b1; ped_a = ped; end
    @(negedge clk);
    tick_a = 1'b0; tick_b = 1'b0; ped_a = 1'b0; ped_b = 1'b0;
    check(b, tag);
    @(negedge clk);
    check(b, {tag, "+1"});
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_ped_b();
    ped_b = 1'b1;
    @(negedge clk);
    ped_b = 1'b0;
    @(negedge clk);
  endtask

  // Short-cycle reference: phase table walked by tick count since ALL_RED_A.
  function automatic void model_a(input int n, output logic [5:0] l,
                                  output int r, output bit ps);
    logic [5:0] lam [6];
    int d [6];
    int t, st;
    lam = '{L_AR, L_NSG, L_NSY, L_AR, L_EWG, L_EWY};
    d   = '{1, 4, 2, 1, 3, 2};
    t = n % 13; st = 0;
    l = L_AR; r = 0; ps = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (t >= st && t < st + d[i]) begin
        l = lam[i]; r = d[i] - 1 - (t - st); ps = (t == st);
      end
      st += d[i];
    end
  endfunction

  // Opposing greens must never be lit together.
  always @(negedge clk) begin
    if (!rst_a && !rst_b) begin
      compared++;
      assert (!(ns_a[0] && ew_a[0]) && !(ns_b[0] && ew_b[0])) else begin
        mismatched++;
        $error("FAIL green_overlap: got a=%b/%b b=%b/%b, want no double green",
               ns_a, ew_a, ns_b, ew_b);
      end
    end
  end

  initial begin
    logic [5:0] l;
    int r;
    bit ps;
    rst_a = 1'b1; rst_b = 1'b1;
    tick_a = 1'b0; tick_b = 1'b0; ped_a = 1'b0; ped_b = 1'b0;
`ifdef TRAFFIC_FLASH_EN
    flash_a = 1'b0; flash_b = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    push(L_AR, 0, 0, 0); check(0, "reset_a");
    push(L_AR, 0, 0, 0); check(1, "reset_b");
    @(negedge clk);

    // Two full short cycles.
    for (int n = 1; n <= 26; n++) begin
      model_a(n, l, r, ps);
      tick(0, l, 0, r, ps, 0, $sformatf("cyc_t%0d", n));
    end

`ifdef TRAFFIC_FLASH_EN
    push(6'b010_010, 0, 0, 1);
    flash_a = 1'b1;
    @(negedge clk); check(0, "flash_enter");
    push(6'b010_010, 0, 0, 0);
    @(negedge clk); check(0, "flash_hold");
    tick(0, 6'b000_000, 0, 0, 0, 0, "flash_t1");
    tick(0, 6'b010_010, 0, 0, 0, 0, "flash_t2");
    tick(0, 6'b000_000, 0, 0, 0, 0, "flash_t3");
    flash_a = 1'b0;
    tick(0, L_AR, 0, 0, 1, 0, "flash_exit");
`endif

    // Run to EW_YELLOW remain=1, then reset asynchronously mid-phase.
    for (int n = 1; n <= 11; n++) begin
      model_a(n, l, r, ps);
      tick(0, l, 0, r, ps, 0, $sformatf("pre_rst_t%0d", n));
    end
    #2 rst_a = 1'b1;
    #1 push(L_AR, 0, 0, 0); check(0, "rst_mid_phase");
    @(negedge clk); rst_a = 1'b0;

    // Pedestrian clamp from remain=20.
    tick(1, L_NSG, 0, 29, 1, 0, "b_ns_enter");
    for (int k = 28; k >= 20; k--) tick(1, L_NSG, 0, k, 0, 0, "b_ns_down");
    pulse_ped_b();
    tick(1, L_NSG, 0, 5, 0, 0, "b_clamp");
    for (int k = 4; k >= 0; k--) tick(1, L_NSG, 0, k, 0, 0, "b_ns_tail");
    tick(1, L_NSY, 0, 1, 1, 0, "b_nsy");
    tick(1, L_NSY, 0, 0, 0, 0, "b_nsy0");
    tick(1, L_AR,  0, 0, 1, 0, "b_arb");
    tick(1, L_EWG, 1, 2, 1, 0, "b_walk_enter");
    tick(1, L_EWG, 1, 1, 0, 0, "b_walk_mid");
    tick(1, L_EWG, 1, 0, 0, 0, "b_walk_end");
    tick(1, L_EWY, 0, 1, 1, 0, "b_walk_clear");
    tick(1, L_EWY, 0, 0, 0, 0, "b_ewy0");
    tick(1, L_AR,  0, 0, 1, 0, "b_ara");
    tick(1, L_NSG, 0, 29, 1, 0, "b_ns2_enter");
    tick(1, L_NSG, 0, 28, 0, 0, "b_pend_cleared");

    // Request at remain=3: no clamp, walk still granted.
    for (int k = 27; k >= 3; k--) tick(1, L_NSG, 0, k, 0, 0, "b_ns2_down");
    pulse_ped_b();
    tick(1, L_NSG, 0, 2, 0, 0, "b_noclamp");
    tick(1, L_NSG, 0, 1, 0, 0, "b_nc1");
    tick(1, L_NSG, 0, 0, 0, 0, "b_nc0");
    tick(1, L_NSY, 0, 1, 1, 0, "b_nsy2");
    tick(1, L_NSY, 0, 0, 0, 0, "b_nsy2_0");
    tick(1, L_AR,  0, 0, 1, 0, "b_arb2");
    tick(1, L_EWG, 1, 2, 1, 0, "b_walk2_enter");
    tick(1, L_EWG, 1, 1, 0, 0, "b_walk2_mid");
    tick(1, L_EWG, 1, 0, 0, 0, "b_walk2_end");
    tick(1, L_EWY, 0, 1, 1, 0, "b_ewy2");
    tick(1, L_EWY, 0, 0, 0, 0, "b_ewy2_0");
    tick(1, L_AR,  0, 0, 1, 0, "b_ara2");
    tick(1, L_NSG, 0, 29, 1, 0, "b_ns3_enter");

    // Request coincident with a tick: clamp deferred by one tick.
    for (int k = 28; k >= 20; k--) tick(1, L_NSG, 0, k, 0, 0, "b_ns3_down");
    tick(1, L_NSG, 0, 19, 0, 1, "b_coinc");
    tick(1, L_NSG, 0, 5, 0, 0, "b_coinc_clamp");

    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
